// File: rtl/done_log_pkg.sv
// Shared types and defaults for the done-event logger: the event record layout
// and the occupancy-width helper used by the logger and its FIFO.
package done_log_pkg;

    localparam int TS_WIDTH_DEF  = 16;
    localparam int SEQ_WIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int LVL_W         = $clog2(DEPTH_DEF) + 1;

    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0]  ts;
        logic [SEQ_WIDTH_DEF-1:0] seq;
    } evt_rec_t;

    // Occupancy counts 0..depth inclusive, so it needs one bit beyond the address.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO of event records. Pointers carry a wrap bit so full and
// empty fall out of a pointer compare. A push while full is taken only with a same-cycle pop.
module evt_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_level = wr_ptr - rd_ptr;
    assign rd_en   = i_pop & ~o_empty;
    assign wr_en   = i_push & (~o_full | rd_en);
    assign o_rdata = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage is reset because the head word drives o_ts/o_seq, which must read 0 out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/done_event_logger.sv
// Captures each rising edge of the asynchronous done level, tags it with a
// timestamp and sequence number, and queues it for a valid/ready consumer.
module done_event_logger
    import done_log_pkg::*;
#(
    parameter int  TS_WIDTH  = TS_WIDTH_DEF,
    parameter int  SEQ_WIDTH = SEQ_WIDTH_DEF,
    parameter int  DEPTH     = DEPTH_DEF,
    localparam int LW        = lvl_width(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ena,
    input  logic                 i_done,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [TS_WIDTH-1:0]  o_ts,
    output logic [SEQ_WIDTH-1:0] o_seq,
    output logic [LW-1:0]        o_level,
    output logic                 o_overflow,
    input  logic                 i_clr_ovf
);

    typedef struct packed {
        logic [TS_WIDTH-1:0]  ts;
        logic [SEQ_WIDTH-1:0] seq;
    } rec_t;

    logic                 s1, s2, s3;
    logic [TS_WIDTH-1:0]  ts_cnt;
    logic [SEQ_WIDTH-1:0] seq_cnt;
    logic                 edge_det;
    logic                 evt;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 full;
    logic                 empty;
    rec_t                 wr_rec;
    rec_t                 rd_rec;

    // s1/s2 resolve metastability; s3 is the previous s2 for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_done;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;
    assign evt      = edge_det & i_ena;
    assign pop      = o_valid & i_ready;
    assign drop     = evt & full & ~pop;
    assign push     = evt & ~drop;

    // Sequence advances on dropped events too, so consumers see the gap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_cnt     <= '0;
            seq_cnt    <= '0;
            o_overflow <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (evt) seq_cnt <= seq_cnt + SEQ_WIDTH'(1);
            if (drop)           o_overflow <= 1'b1;
            else if (i_clr_ovf) o_overflow <= 1'b0;
        end
    end

    assign wr_rec = '{ts: ts_cnt, seq: seq_cnt};

    evt_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_wdata (wr_rec),
        .i_pop   (pop),
        .o_rdata (rd_rec),
        .o_full  (full),
        .o_empty (empty),
        .o_level (o_level)
    );

    assign o_valid = ~empty;
    assign o_ts    = rd_rec.ts;
    assign o_seq   = rd_rec.seq;

endmodule
